// File: rtl/user_record_store.sv
// Per-user record memory: NUM_USERS x NUM_FIELDS fields with per-entry valid bits,
// a single valid/ready command port (write / read / saturating accumulate / swept clear).

module user_record_entry #(
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = 12,
    parameter int FW         = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [FW-1:0]                      wr_field,
    input  logic [FIELD_W-1:0]                 wr_data,
    input  logic                               clr,
    output logic [NUM_FIELDS-1:0][FIELD_W-1:0] data,
    output logic [NUM_FIELDS-1:0]              vld
);

    // Data is deliberately left unreset; the valid bits mask stale contents.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (clr)
                data[f] <= '0;
            else if (wr_en && wr_field == FW'(f))
                data[f] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (clr)
                    vld[f] <= 1'b0;
                else if (wr_en && wr_field == FW'(f))
                    vld[f] <= 1'b1;
            end
        end
    end

endmodule

module user_record_store #(
    parameter int NUM_USERS  = 32,
    parameter int NUM_FIELDS = 2,
    parameter int FIELD_W    = 12,
    parameter int UW         = (NUM_USERS  > 1) ? $clog2(NUM_USERS)  : 1,
    parameter int FW         = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [UW-1:0]      cmd_user,
    input  logic [FW-1:0]      cmd_field,
    input  logic [FIELD_W-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [FIELD_W-1:0] rsp_data,
    output logic               rsp_hit,
    output logic               rsp_sat,
    output logic               rsp_err,
    output logic               busy
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ACCUM = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [UW:0]   USERS_LIM  = (UW+1)'(NUM_USERS);
    localparam logic [FW:0]   FIELDS_LIM = (FW+1)'(NUM_FIELDS);
    localparam logic [UW-1:0] LAST_USER  = UW'(NUM_USERS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    typedef struct packed {
        logic               valid;
        logic [FIELD_W-1:0] data;
        logic               hit;
        logic               sat;
        logic               err;
    } rsp_t;

    state_t state_q, state_d;
    logic [UW-1:0] cnt_q;
    rsp_t rsp_q, rsp_d;

    logic [NUM_USERS-1:0][NUM_FIELDS-1:0][FIELD_W-1:0] rec_data;
    logic [NUM_USERS-1:0][NUM_FIELDS-1:0]              rec_vld;

    logic               accept;
    logic               in_range;
    logic               old_vld;
    logic [FIELD_W-1:0] old_data;
    logic [FIELD_W:0]   sum;
    logic               sat;
    logic [FIELD_W-1:0] acc_res;
    logic               wr_any;
    logic [FIELD_W-1:0] wr_data;
    logic               sweep;

    assign accept = cmd_valid && cmd_ready;

    // Lookup of the addressed entry; an unwritten entry reads as zero for ACCUM.
    always_comb begin
        in_range = ({1'b0, cmd_user} < USERS_LIM) && ({1'b0, cmd_field} < FIELDS_LIM);
        old_vld  = 1'b0;
        old_data = '0;
        if (in_range) begin
            old_vld = rec_vld[cmd_user][cmd_field];
            if (old_vld)
                old_data = rec_data[cmd_user][cmd_field];
        end
        sum     = {1'b0, old_data} + {1'b0, cmd_data};
        sat     = sum[FIELD_W];
        acc_res = sat ? '1 : sum[FIELD_W-1:0];
        wr_any  = accept && in_range && (cmd_op == OP_WRITE || cmd_op == OP_ACCUM);
        wr_data = (cmd_op == OP_ACCUM) ? acc_res : cmd_data;
    end

    for (genvar u = 0; u < NUM_USERS; u++) begin : g_user
        user_record_entry #(
            .NUM_FIELDS (NUM_FIELDS),
            .FIELD_W    (FIELD_W),
            .FW         (FW)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_any && cmd_user == UW'(u)),
            .wr_field (cmd_field),
            .wr_data  (wr_data),
            .clr      (sweep && cnt_q == UW'(u)),
            .data     (rec_data[u]),
            .vld      (rec_vld[u])
        );
    end

    // Sweep FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && cmd_op == OP_CLEAR) state_d = S_CLEAR;
            S_CLEAR: if (cnt_q == LAST_USER) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sweep     = (state_q == S_CLEAR);
        busy      = sweep;
        cmd_ready = (state_q == S_IDLE) && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (sweep && cnt_q != LAST_USER)
            cnt_q <= cnt_q + UW'(1);
        else
            cnt_q <= '0;
    end

    // Response: registered one cycle after acceptance, all-zero when idle.
    always_comb begin
        rsp_d = '0;
        if (accept) begin
            case (cmd_op)
                OP_WRITE: begin
                    rsp_d.valid = !in_range;
                    rsp_d.err   = !in_range;
                end
                OP_READ: begin
                    rsp_d.valid = 1'b1;
                    rsp_d.err   = !in_range;
                    rsp_d.hit   = old_vld;
                    rsp_d.data  = old_data;
                end
                OP_ACCUM: begin
                    rsp_d.valid = 1'b1;
                    rsp_d.err   = !in_range;
                    if (in_range) begin
                        rsp_d.hit  = 1'b1;
                        rsp_d.sat  = sat;
                        rsp_d.data = acc_res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_q <= '0;
        else
            rsp_q <= rsp_d;
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_data  = rsp_q.data;
    assign rsp_hit   = rsp_q.hit;
    assign rsp_sat   = rsp_q.sat;
    assign rsp_err   = rsp_q.err;

endmodule
